flopr_stage: RTL and testbench

- Parameterized pipeline register used between CPU pipeline stages, e.g. the decode-to-execute bundle of control bits, register data, immediate and PC.
- Captures a WIDTH-bit bundle on the rising clock edge and presents it on the next stage's inputs.
- Supports stall (enable), flush (synchronous clear) and optional multi-stage delay.
- With en=1 and clr=0 it behaves as a plain resettable D flip-flop bank.

---
 rtl/flopr_stage.sv | 78 +++++++
 tb/tb_flopr_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/flopr_stage.sv
// -----------------------------------------------------------------------------
// flopr_stage
//
// Pipeline register placed between CPU pipeline stages (for example the
// decode-to-execute bundle of control bits, register data, immediate and PC).
// A WIDTH-bit bundle is captured on the rising clock edge and passed through
// STAGES register stages in series, so the latency is STAGES cycles.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-low reset; forces every stage to
//                      RESET_VALUE immediately
//   en     in   1      capture enable; 0 stalls (holds) every stage
//   clr    in   1      synchronous flush; loads RESET_VALUE into every stage,
//                      takes priority over en
//   d      in   WIDTH  data in
//   q      out  WIDTH  data out, taken straight from the last stage's flops
//
// There is no handshake: the upstream and downstream stages share the global
// en/clr controls, so a stall freezes the whole chain and nothing is dropped.
// All bits are treated identically; no field is interpreted.
// -----------------------------------------------------------------------------
module flopr_stage #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               STAGES      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Parameter sanity, checked when the design is elaborated.
  if (STAGES < 1 || WIDTH < 1) begin : g_bad_param
    $error("flopr_stage: STAGES and WIDTH must both be >= 1");
  end

  // Output of each stage; element i feeds stage i+1.
  logic [WIDTH-1:0] stage_out [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] stage_in;
    logic [WIDTH-1:0] stage_d;
    logic [WIDTH-1:0] stage_q;

    if (i == 0) begin : g_first
      assign stage_in = d;
    end else begin : g_chain
      assign stage_in = stage_out[i-1];
    end

    // Flush beats stall; stall simply recirculates the current contents.
    always_comb begin
      stage_d = stage_q;
      if (clr) begin
        stage_d = RESET_VALUE;
      end else if (en) begin
        stage_d = stage_in;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stage_q <= RESET_VALUE;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign stage_out[i] = stage_q;
  end

  assign q = stage_out[STAGES-1];

endmodule

// File: tb/tb_flopr_stage.sv
// -----------------------------------------------------------------------------
// tb_flopr_stage
//
// Four instances of flopr_stage share the same clock, reset, en, clr and d:
//   0: WIDTH=32,  RESET_VALUE=0,          STAGES=1
//   1: WIDTH=109, RESET_VALUE=0,          STAGES=1
//   2: WIDTH=32,  RESET_VALUE=0xFFFF0000, STAGES=1
//   3: WIDTH=32,  RESET_VALUE=0,          STAGES=3
// A delay-line model (one queue per instance, oldest entry = q) is compared
// against every instance on each falling clock edge, and directed literal
// expectations pin both the model and the design.
// -----------------------------------------------------------------------------
module tb_flopr_stage;

  localparam int W = 109;
  localparam int N = 4;

  localparam logic [W-1:0] RV   [N] = '{109'h0, 109'h0, 109'hFFFF0000, 109'h0};
  localparam logic [W-1:0] MASK [N] = '{109'hFFFFFFFF, {109{1'b1}}, 109'hFFFFFFFF, 109'hFFFFFFFF};
  localparam int           ST   [N] = '{1, 1, 1, 3};

  // ---------------------------------------------------------------- clock/reset
  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         en    = 1'b0;
  logic         clr   = 1'b0;
  logic [W-1:0] d     = '0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  logic [31:0]  q_a, q_f, q_m;
  logic [W-1:0] q_w;
  logic [W-1:0] dq [N];

  flopr_stage #(.WIDTH(32), .RESET_VALUE(32'h0), .STAGES(1)) u_a (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d[31:0]), .q(q_a));
  flopr_stage #(.WIDTH(W), .RESET_VALUE('0), .STAGES(1)) u_w (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d), .q(q_w));
  flopr_stage #(.WIDTH(32), .RESET_VALUE(32'hFFFF0000), .STAGES(1)) u_f (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d[31:0]), .q(q_f));
  flopr_stage #(.WIDTH(32), .RESET_VALUE(32'h0), .STAGES(3)) u_m (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d[31:0]), .q(q_m));

  assign dq[0] = {77'b0, q_a};
  assign dq[1] = q_w;
  assign dq[2] = {77'b0, q_f};
  assign dq[3] = {77'b0, q_m};

  // ---------------------------------------------------------------- counters
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // ---------------------------------------------------------------- model
  // Each instance is a delay line holding exactly STAGES values; the oldest
  // one is what q must show.
  logic [W-1:0] hist [N][$];

  task automatic model_fill();
    for (int k = 0; k < N; k++) begin
      hist[k].delete();
      repeat (ST[k]) hist[k].push_back(RV[k]);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset || clr) begin
      model_fill();
    end else if (en) begin
      for (int k = 0; k < N; k++) begin
        hist[k].push_back(d & MASK[k]);
        void'(hist[k].pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < N; k++) begin
        checks++;
        if (dq[k] !== hist[k][0]) begin
          errors++;
          $display("FAIL model_q[%0d] t=%0t got %h exp %h", k, $time, dq[k], hist[k][0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Inputs change 1 time unit after the rising edge, well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [W-1:0] v);
    en  = e;
    clr = c;
    d   = v;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    model_fill();
    #1 reset = 1'b0;
    #2;
    check("reset_a", dq[0], 109'h0);
    check("reset_w", dq[1], 109'h0);
    check("reset_f", dq[2], 109'hFFFF0000);
    check("reset_m", dq[3], 109'h0);
    tick();
    check("reset_held_f", dq[2], 109'hFFFF0000);
    reset  = 1'b1;
    chk_on = 1'b1;

    // Asynchronous reset pulse between edges.
    drive(1, 0, 109'hDEADBEEF);
    tick();
    check("capture_a", dq[0], 109'hDEADBEEF);
    #2 reset = 1'b0;
    #1;
    check("async_rst_a", dq[0], 109'h0);
    check("async_rst_f", dq[2], 109'hFFFF0000);
    reset = 1'b1;
    tick();
    check("first_edge_a", dq[0], 109'hDEADBEEF);

    // Pass-through.
    drive(1, 0, 109'h1); tick(); check("pass_1", dq[0], 109'h1);
    drive(1, 0, 109'h2); tick(); check("pass_2", dq[0], 109'h2);
    drive(1, 0, 109'h3); tick(); check("pass_3", dq[0], 109'h3);
    drive(1, 0, {W{1'b1}}); tick();
    check("wide_ones", dq[1], {W{1'b1}});
    check("narrow_ones", dq[0], 109'hFFFFFFFF);

    // Stall.
    drive(1, 0, 109'hA5); tick(); check("stall_load", dq[0], 109'hA5);
    drive(0, 0, 109'h5A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", dq[0], 109'hA5);
    end
    drive(1, 0, 109'h5A); tick(); check("stall_release", dq[0], 109'h5A);

    // Flush priority over en.
    drive(1, 0, 109'h1234); tick(); check("flush_load", dq[2], 109'h1234);
    drive(0, 1, 109'h1234); tick();
    check("flush_en0_f", dq[2], 109'hFFFF0000);
    check("flush_en0_a", dq[0], 109'h0);
    drive(1, 0, 109'h1234); tick(); check("flush_reload", dq[2], 109'h1234);
    drive(1, 1, 109'h1234); tick();
    check("flush_en1_f", dq[2], 109'hFFFF0000);
    check("flush_en1_m", dq[3], 109'h0);

    // Multi-stage latency and stall inside the chain.
    drive(1, 0, 109'h11); tick(); check("multi_e1", dq[3], 109'h0);
    drive(1, 0, 109'h22); tick(); check("multi_e2", dq[3], 109'h0);
    drive(1, 0, 109'h33); tick(); check("multi_11", dq[3], 109'h11);
    drive(1, 0, 109'h44); tick(); check("multi_22", dq[3], 109'h22);
    drive(0, 0, 109'h77); tick(); check("multi_stall1", dq[3], 109'h22);
    tick();                       check("multi_stall2", dq[3], 109'h22);
    drive(1, 0, 109'h55); tick(); check("multi_33", dq[3], 109'h33);
    tick();                       check("multi_44", dq[3], 109'h44);

    // Reset with data in flight.
    drive(1, 0, 109'h66); tick();
    drive(1, 0, 109'h77); tick();
    #2 reset = 1'b0;
    #1;
    check("midflight_rst", dq[3], 109'h0);
    reset = 1'b1;
    drive(1, 0, 109'h88); tick(); check("post_rst_1", dq[3], 109'h0);
    drive(1, 0, 109'h99); tick(); check("post_rst_2", dq[3], 109'h0);
    drive(1, 0, 109'hAA); tick(); check("post_rst_88", dq[3], 109'h88);
    tick();                       check("post_rst_99", dq[3], 109'h99);

    repeat (3) tick();
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
